// File: rtl/gpio_pkg.sv
// Shared GPIO parameters. The GPIO register/interrupt block imports the
// same GPIO_WIDTH, so the pin count is defined in exactly one place.
package gpio_pkg;

  localparam int GPIO_WIDTH       = 32;
  localparam int GPIO_DB_CNT_W    = 16;
  localparam int GPIO_SYNC_STAGES = 2;

endpackage : gpio_pkg

// File: rtl/gpio_in_debounce_bit.sv
// Single-pin conditioner: synchroniser chain, debounce counter, stable
// register and registered edge pulses.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pad_in          raw pad level, asynchronous to clk
//   debounce_en     1 = apply debounce_limit, 0 = bypass (limit 0)
//   debounce_limit  extra stable cycles required before committing
//   gpio_in         conditioned level (stable register)
//   rise_pulse      1-cycle pulse coincident with gpio_in 0->1
//   fall_pulse      1-cycle pulse coincident with gpio_in 1->0
module gpio_in_debounce_bit
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int CNT_W       = GPIO_DB_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pad_in,
  input  logic             debounce_en,
  input  logic [CNT_W-1:0] debounce_limit,
  output logic             gpio_in,
  output logic             rise_pulse,
  output logic             fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       eff_limit;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Bit 0 takes the pad; the MSB is the fully synchronised value.
  assign sync = sync_q[SYNC_STAGES-1];

  // Bypass is just a zero limit, so both modes share one datapath.
  assign eff_limit = debounce_en ? debounce_limit : '0;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= eff_limit) begin
      // >= rather than == so a limit lowered below a running count still
      // commits on the next disagreeing cycle.
      stable_d = sync;
      cnt_d    = '0;
      rise_d   = sync;
      fall_d   = ~sync;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pad_in};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign gpio_in    = stable_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule : gpio_in_debounce_bit

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: synchronises and optionally debounces every pad,
// producing the conditioned gpio_in bus for the GPIO block plus per-pin
// single-cycle rise/fall pulses.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pad_in          raw pad levels (asynchronous)
//   debounce_en     per-pin debounce enable (quasi-static)
//   debounce_limit  shared debounce limit (quasi-static)
//   gpio_in         conditioned, registered levels
//   rise_pulse      per-pin 0->1 pulses, coincident with gpio_in
//   fall_pulse      per-pin 1->0 pulses, coincident with gpio_in
module gpio_in_conditioner
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int CNT_W       = GPIO_DB_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad_in,
  input  logic [WIDTH-1:0] debounce_en,
  input  logic [CNT_W-1:0] debounce_limit,
  output logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_in_debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_bit (
      .clk           (clk),
      .rst_n         (rst_n),
      .pad_in        (pad_in[i]),
      .debounce_en   (debounce_en[i]),
      .debounce_limit(debounce_limit),
      .gpio_in       (gpio_in[i]),
      .rise_pulse    (rise_pulse[i]),
      .fall_pulse    (fall_pulse[i])
    );
  end

endmodule : gpio_in_conditioner
